serial_bit_feeder: RTL and testbench

//  Parallel-to-serial front end for the serial sequence-detector FSM. Accepts

---
 rtl/serial_bit_feeder_if.sv | 33 +++
 rtl/serial_bit_feeder.sv | 118 +++++++++++
 tb/tb_serial_bit_feeder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_bit_feeder_if.sv
// Load handshake and serial-stream signals of the serial bit feeder.
// master drives words and pacing; slave is the feeder itself.
interface serial_bit_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             x_out;
  logic             x_valid;
  logic             frame_start;

  modport master (
    output load_data,
    output load_valid,
    output shift_en,
    input  load_ready,
    input  x_out,
    input  x_valid,
    input  frame_start
  );

  modport slave (
    input  load_data,
    input  load_valid,
    input  shift_en,
    output load_ready,
    output x_out,
    output x_valid,
    output frame_start
  );
endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder with a one-word hold buffer; first bit appears the cycle after acceptance.
// Backpressure: load_ready drops while the hold buffer is full; shift_en=0 freezes the stream.
module serial_bit_feeder #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  serial_bit_feeder_if.slave   bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     word_count
);

  localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             hold_full_q, hold_full_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;

  logic             accept;
  logic             on_last_bit;
  logic             advance;
  logic             shifter_free;
  logic [WIDTH-1:0] shreg_shifted;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      hold_data_q  <= '0;
      hold_full_q  <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      hold_data_q  <= hold_data_d;
      hold_full_q  <= hold_full_d;
      word_count_q <= word_count_d;
    end
  end

  // Shift toward whichever end feeds x_out.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    hold_data_d  = hold_data_q;
    hold_full_d  = hold_full_q;
    word_count_d = word_count_q;

    accept       = bus.load_valid && !hold_full_q;
    on_last_bit  = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
    advance      = (state_q == SHIFT) && bus.shift_en;
    shifter_free = (state_q == IDLE) || (on_last_bit && bus.shift_en);

    if (advance) begin
      if (!on_last_bit) begin
        shreg_d   = shreg_shifted;
        bit_cnt_d = bit_cnt_q + 1'b1;
      end else begin
        word_count_d = word_count_q + 1'b1;
        bit_cnt_d    = '0;
        if (hold_full_q) begin
          shreg_d     = hold_data_q;
          hold_full_d = 1'b0;
        end else if (!accept) begin
          state_d = IDLE;
        end
      end
    end

    // accept implies the hold buffer is empty, so it never collides with the hold->shreg move.
    if (accept) begin
      if (shifter_free) begin
        shreg_d   = bus.load_data;
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end else begin
        hold_data_d = bus.load_data;
        hold_full_d = 1'b1;
      end
    end
  end

  always_comb begin
    bus.load_ready  = !hold_full_q;
    bus.x_valid     = (state_q == SHIFT);
    bus.frame_start = (state_q == SHIFT) && (bit_cnt_q == '0);
    bus.x_out       = IDLE_LEVEL;
    if (state_q == SHIFT) begin
      bus.x_out = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    end
    busy       = (state_q == SHIFT) || hold_full_q;
    word_count = word_count_q;
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Scoreboard bench: two feeders (MSB-first/idle 0 and LSB-first/idle 1) share one stimulus stream.
module tb_serial_bit_feeder;
  localparam int W     = 8;
  localparam int CNT_W = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic         lv = 1'b0;
  logic         se = 1'b1;
  logic [W-1:0] ld = '0;

  serial_bit_feeder_if #(.WIDTH(W)) bus0 ();
  serial_bit_feeder_if #(.WIDTH(W)) bus1 ();

  assign bus0.load_valid = lv;
  assign bus0.load_data  = ld;
  assign bus0.shift_en   = se;
  assign bus1.load_valid = lv;
  assign bus1.load_data  = ld;
  assign bus1.shift_en   = se;

  logic             busy0, busy1;
  logic [CNT_W-1:0] wc0, wc1;

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .CNT_W(CNT_W)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0), .busy(busy0), .word_count(wc0));
  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1), .CNT_W(CNT_W)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1), .busy(busy1), .word_count(wc1));

  typedef struct {
    logic b;
    logic first;
    logic last;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  int   words_done[2];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   stop_se  = 1'b0;

  function automatic void check(input string nm, input int lane, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s lane%0d: got %0h expected %0h at %0t", nm, lane, act, exp, $time);
  endfunction

  // Reference: a word is just its bits in wire order; the stream is the concatenation of accepted words.
  function automatic void push_word(input int lane, input logic [W-1:0] w);
    ent_t e;
    for (int i = 0; i < W; i++) begin
      e.b     = (lane == 0) ? w[W-1-i] : w[i];
      e.first = (i == 0);
      e.last  = (i == W-1);
      if (lane == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endfunction

  always @(posedge clock) begin
    if (reset === 1'b1) begin
      if (bus0.load_valid && bus0.load_ready) push_word(0, bus0.load_data);
      if (bus1.load_valid && bus1.load_ready) push_word(1, bus1.load_data);
    end
  end

  task automatic mon_lane(input int lane, input logic xo, input logic xv, input logic fs,
                          input logic lr, input logic bz, input logic [CNT_W-1:0] wc,
                          input logic idle, input logic sen);
    ent_t e;
    int   sz;
    int   cnt;
    sz  = (lane == 0) ? q0.size() : q1.size();
    cnt = words_done[lane];
    check("x_valid", lane, xv, sz != 0);
    check("busy", lane, bz, sz != 0);
    check("load_ready", lane, lr, sz <= W);
    check("word_count", lane, wc, cnt[CNT_W-1:0]);
    if (sz != 0) begin
      e = (lane == 0) ? q0[0] : q1[0];
      check("x_out", lane, xo, e.b);
      check("frame_start", lane, fs, e.first);
      if (sen) begin
        if (lane == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
        if (e.last) words_done[lane] = (words_done[lane] + 1) % (1 << CNT_W);
      end
    end else begin
      check("x_out_idle", lane, xo, idle);
      check("frame_start_idle", lane, fs, 1'b0);
    end
  endtask

  always @(negedge clock) begin
    if (reset === 1'b1) begin
      mon_lane(0, bus0.x_out, bus0.x_valid, bus0.frame_start, bus0.load_ready, busy0, wc0, 1'b0, se);
      mon_lane(1, bus1.x_out, bus1.x_valid, bus1.frame_start, bus1.load_ready, busy1, wc1, 1'b1, se);
    end
  end

  task automatic reset_checks();
    check("rst_x_valid", 0, bus0.x_valid, 1'b0);
    check("rst_busy", 0, busy0, 1'b0);
    check("rst_load_ready", 0, bus0.load_ready, 1'b1);
    check("rst_word_count", 0, wc0, 0);
    check("rst_x_out", 0, bus0.x_out, 1'b0);
    check("rst_frame_start", 0, bus0.frame_start, 1'b0);
    check("rst_x_valid", 1, bus1.x_valid, 1'b0);
    check("rst_busy", 1, busy1, 1'b0);
    check("rst_load_ready", 1, bus1.load_ready, 1'b1);
    check("rst_word_count", 1, wc1, 0);
    check("rst_x_out", 1, bus1.x_out, 1'b1);
    check("rst_frame_start", 1, bus1.frame_start, 1'b0);
  endtask

  task automatic send(input logic [W-1:0] w);
    logic acc;
    acc = 1'b0;
    lv  = 1'b1;
    ld  = w;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clock);
      acc = bus0.load_ready;
      @(posedge clock);
      #1;
    end
    if (!acc) check("send_timeout", 0, acc, 1'b1);
    lv = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    words_done[0] = 0;
    words_done[1] = 0;
  endtask

  initial begin
    clear_model();
    repeat (2) @(posedge clock);
    #2;
    reset_checks();
    @(posedge clock);
    #1;
    reset = 1'b1;

    // single word, full-speed shifting
    send(8'hB4);
    idle_cycles(12);

    // held valid: three words back to back, second and third via the hold buffer
    send(8'hFF);
    send(8'h00);
    send(8'hF0);
    idle_cycles(30);

    // half-rate pacing
    stop_se = 1'b0;
    fork
      begin
        send(8'hC3);
        idle_cycles(20);
        stop_se = 1'b1;
      end
      begin
        while (!stop_se) begin
          @(posedge clock);
          #1;
          se = ~se;
        end
      end
    join
    se = 1'b1;
    idle_cycles(4);

    send(8'h01);
    idle_cycles(12);

    // asynchronous reset in the middle of a word with another word held
    send(8'hA5);
    send(8'h3C);
    idle_cycles(2);
    #1;
    reset = 1'b0;
    clear_model();
    #1;
    reset_checks();
    @(posedge clock);
    #1;
    reset = 1'b1;
    send(8'h81);
    idle_cycles(12);

    // random stream with random pacing, enough words to wrap word_count
    stop_se = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          if ($urandom_range(3, 0) == 0) idle_cycles($urandom_range(3, 0));
          send(W'($urandom));
        end
        stop_se = 1'b1;
      end
      begin
        while (!stop_se) begin
          @(posedge clock);
          #1;
          se = ($urandom_range(3, 0) != 0);
        end
      end
    join
    se = 1'b1;

    for (int k = 0; k < 100 && (q0.size() != 0 || q1.size() != 0); k++) idle_cycles(1);
    check("drain_timeout", 0, q0.size() + q1.size(), 0);
    idle_cycles(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
